// File: rtl/hex_digits_pio_ext.sv
// hex_digits_pio_ext: Avalon-MM output port for NUM_DIGITS hex digits.
// Atomic SET/CLEAR/TOGGLE on the digit register and per-digit blinking
// driven by a free-running prescaler. out_port carries the digit values,
// out_blank tells the downstream seven-segment decoder which digits to hide.
//
// Bus handshake: there is no waitrequest and no valid/ready pair. A write is
// accepted on every rising clk edge where chipselect && !write_n. Reads are
// combinational from address with zero wait states and ignore chipselect.
module hex_digits_pio_ext #(
  parameter int          NUM_DIGITS   = 4,
  parameter int          DIGIT_WIDTH  = 4,
  parameter int          CNT_WIDTH    = 24,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter logic [31:0] RESET_PERIOD = 32'h0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2:0]                        address,
  input  logic                              chipselect,
  input  logic                              write_n,
  input  logic [31:0]                       writedata,
  output logic [31:0]                       readdata,
  output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] out_port,
  output logic [NUM_DIGITS-1:0]             out_blank
);

  localparam int DW = NUM_DIGITS * DIGIT_WIDTH;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_SET      = 3'd2;
  localparam logic [2:0] ADDR_CLEAR    = 3'd3;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  logic [DW-1:0]         data_q,     data_d;
  logic [NUM_DIGITS-1:0] blink_en_q, blink_en_d;
  logic [CNT_WIDTH-1:0]  period_q,   period_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
  logic                  phase_q,    phase_d;
  logic [NUM_DIGITS-1:0] blank_q,    blank_d;

  logic                  wr_en;
  logic [DW-1:0]         wd_data;
  logic                  unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wd_data   = writedata[DW-1:0];
  // Upper write-data bits beyond each register's width are intentionally dropped.
  assign unused_wd = ^writedata;

  // Next values of the software-visible registers (read-modify-write in one edge).
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d     = wd_data;
        ADDR_BLINK_EN: blink_en_d = writedata[NUM_DIGITS-1:0];
        ADDR_SET:      data_d     = data_q | wd_data;
        ADDR_CLEAR:    data_d     = data_q & ~wd_data;
        ADDR_TOGGLE:   data_d     = data_q ^ wd_data;
        ADDR_PERIOD:   period_d   = writedata[CNT_WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  // Blink prescaler: a period write restarts it visible and wins over expiry.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && address == ADDR_PERIOD) begin
      cnt_d   = writedata[CNT_WIDTH-1:0];
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - CNT_WIDTH'(1);
    end
    blank_d = blink_en_d & ~{NUM_DIGITS{phase_d}};
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE[DW-1:0];
      blink_en_q <= '0;
      period_q   <= RESET_PERIOD[CNT_WIDTH-1:0];
      cnt_q      <= RESET_PERIOD[CNT_WIDTH-1:0];
      phase_q    <= 1'b1;
      blank_q    <= '0;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      blank_q    <= blank_d;
    end
  end

  assign out_port  = data_q;
  assign out_blank = blank_q;

  // Combinational read mux; SET/CLEAR/TOGGLE addresses read back DATA.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: readdata[DW-1:0] = data_q;
      ADDR_BLINK_EN: readdata[NUM_DIGITS-1:0] = blink_en_q;
      ADDR_PERIOD:   readdata[CNT_WIDTH-1:0]  = period_q;
      ADDR_STATUS:   readdata[1:0]            = {(period_q != '0), phase_q};
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_hex_digits_pio_ext.sv
// Directed testbench for hex_digits_pio_ext with default parameters
// (4 digits x 4 bits, RESET_VALUE 0, RESET_PERIOD 0).
module tb_hex_digits_pio_ext;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic [3:0]  out_blank;

  logic [31:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  hex_digits_pio_ext dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_blank  (out_blank)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus write: held for exactly one rising edge, released 1 ns after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Bus read: readdata is combinational, sampled 1 ns after the address.
  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard compare: pop the oldest expectation and compare.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state
    #12;
    expect_val(32'h0); check("rst_out_port", 32'(out_port));
    expect_val(32'h0); check("rst_out_blank", 32'(out_blank));
    rd(3'd6); expect_val(32'h1); check("rst_status", readdata);
    @(posedge clk); #1;
    reset = 1'b0;

    // Atomic operations, back-to-back on consecutive cycles
    wr(3'd0, 32'h0000_00F0);
    wr(3'd2, 32'h0000_000F);
    expect_val(32'h00FF); check("set", 32'(out_port));
    wr(3'd3, 32'h0000_00F0);
    expect_val(32'h000F); check("clear", 32'(out_port));
    wr(3'd4, 32'h0000_FFFF);
    expect_val(32'hFFF0); check("toggle", 32'(out_port));
    rd(3'd4); expect_val(32'h0000_FFF0); check("rd_toggle_addr", readdata);
    rd(3'd2); expect_val(32'h0000_FFF0); check("rd_set_addr", readdata);
    rd(3'd3); expect_val(32'h0000_FFF0); check("rd_clear_addr", readdata);

    // Blinking with period 3: phase flips every 4 edges after the period write
    wr(3'd1, 32'h0000_0005);
    expect_val(32'h0); check("blink_en_no_effect", 32'(out_blank));
    wr(3'd5, 32'h0000_0003);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      expect_val(((k / 4) % 2 == 0) ? 32'h0 : 32'h5);
      check("blink", 32'(out_blank));
      if (k % 4 == 0) begin
        expect_val(32'hFFF0); check("blink_out_port", 32'(out_port));
      end
    end
    rd(3'd6); expect_val(32'h2); check("status_phase0", readdata);

    // Period 0 while invisible: forced visible and held
    wr(3'd5, 32'h0000_0000);
    rd(3'd6); expect_val(32'h1); check("period0_status", readdata);
    expect_val(32'h0); check("period0_blank", 32'(out_blank));
    repeat (10) @(posedge clk);
    #1;
    rd(3'd6); expect_val(32'h1); check("period0_hold_status", readdata);
    expect_val(32'h0); check("period0_hold_blank", 32'(out_blank));

    // Collision: period write in the cycle cnt expires
    wr(3'd5, 32'h0000_0003);
    repeat (3) @(posedge clk);
    #1;
    rd(3'd6); expect_val(32'h3); check("pre_collision", readdata);
    wr(3'd5, 32'h0000_0007);
    rd(3'd6); expect_val(32'h3); check("collision_status", readdata);
    expect_val(32'h0); check("collision_blank", 32'(out_blank));
    repeat (7) @(posedge clk);
    #1;
    rd(3'd6); expect_val(32'h3); check("collision_hold", readdata);
    @(posedge clk); #1;
    rd(3'd6); expect_val(32'h2); check("collision_toggle", readdata);
    expect_val(32'h5); check("collision_blank_on", 32'(out_blank));

    // Width handling and ignored writes
    wr(3'd0, 32'hABCD_1234);
    expect_val(32'h1234); check("width_out_port", 32'(out_port));
    rd(3'd0); expect_val(32'h0000_1234); check("width_readback", readdata);
    rd(3'd7); expect_val(32'h0); check("addr7_read", readdata);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    expect_val(32'h1234); check("ignored_writes", 32'(out_port));
    rd(3'd1); expect_val(32'h5); check("rd_blink_en", readdata);
    rd(3'd5); expect_val(32'h7); check("rd_period", readdata);

    // Asynchronous reset mid-count
    expect_val(32'h5); check("pre_reset_blank", 32'(out_blank));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_val(32'h0); check("async_rst_out_port", 32'(out_port));
    expect_val(32'h0); check("async_rst_out_blank", 32'(out_blank));
    rd(3'd6); expect_val(32'h1); check("async_rst_status", readdata);
    rd(3'd1); expect_val(32'h0); check("async_rst_blink_en", readdata);

    // Write in the cycle of reset deassertion
    @(posedge clk); #1;
    reset = 1'b0;
    wr(3'd0, 32'h0000_BEEF);
    expect_val(32'hBEEF); check("post_rst_write", 32'(out_port));

    if (exp_q.size() != 0) begin
      total_cnt++;
      $error("FAIL leftover_expectations: observed %0d queued expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hex_digits_pio_ext.md
# hex_digits_pio_ext

Parametrised Avalon-MM slave output port driving NUM_DIGITS hex digits, with atomic set/clear/toggle access and per-digit blinking from an internal prescaler. Next-generation replacement for the fixed 16-bit hex-digit PIO in the Nios II SoC; software writes digit values and the block drives the seven-segment decoders through `out_port` and `out_blank`.

## Interface
- NUM_DIGITS, 4, number of digits; 1..8
- DIGIT_WIDTH, 4, bits per digit; DW = NUM_DIGITS*DIGIT_WIDTH must be ≤ 32
- CNT_WIDTH, 24, blink prescaler width; 1..32
- RESET_VALUE, 0, reset value of DATA (DW bits)
- RESET_PERIOD, 0, reset value of BLINK_PERIOD
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above the register width are ignored
- readdata  out  32  read data, combinational, zero wait states; unused bits read 0
- out_port  out  DW  current DATA register
- out_blank  out  NUM_DIGITS  1 = digit i must be blanked by the downstream decoder

## Operation
- A write is accepted when `chipselect && !write_n`.
- Register map:
  - 0 DATA, R/W: plain write.
  - 1 BLINK_EN, R/W, NUM_DIGITS bits: per-digit blink enable.
  - 2 SET, W: DATA |= wd.
  - 3 CLEAR, W: DATA &= ~wd.
  - 4 TOGGLE, W: DATA ^= wd.
  - 5 BLINK_PERIOD, R/W, CNT_WIDTH bits.
  - 6 STATUS, RO: bit0 = phase, bit1 = (BLINK_PERIOD != 0).
- Reads of addresses 2, 3, 4 return DATA; address 7 reads 0; writes to 6 and 7 are ignored.
- `readdata` = mux(address) of current register values, independent of chipselect.
- Blink prescaler `cnt` (CNT_WIDTH bits) and `phase` (1 = visible):
  - BLINK_PERIOD == 0: cnt held at 0, phase held at 1; blinking is disabled.
  - Otherwise, each cycle: if cnt == 0 then cnt <= BLINK_PERIOD and phase <= ~phase; else cnt <= cnt - 1. Phase period = 2*(BLINK_PERIOD+1) cycles.
  - A write to BLINK_PERIOD loads cnt with the new value and forces phase to 1 on the same edge. This takes priority over expiry in the same cycle.
  - A write to BLINK_EN does not affect cnt or phase.
- `out_blank[i] = BLINK_EN[i] & ~phase`, registered.
- `out_port` = DATA, registered; it is never masked by blinking.
- Reset values:
  - DATA = RESET_VALUE; BLINK_EN = 0; BLINK_PERIOD = RESET_PERIOD; cnt = RESET_PERIOD; phase = 1.
  - out_port = RESET_VALUE; out_blank = 0.
- Assertion of reset mid-operation clears all state immediately, asynchronously. Writes in the cycle of reset deassertion are accepted normally.

## Timing
- Register write at edge N: register and `out_port` are updated at edge N; `readdata` reflects the new value in cycle N+1 (1-cycle write-to-output latency).
- SET/CLEAR/TOGGLE are single-cycle read-modify-write in one edge; back-to-back writes on consecutive cycles compose correctly.
- `out_blank` changes on the same edge as `phase`, or on the edge that writes BLINK_EN.
- Read latency 0: combinational from `address`; no waitrequest.

## Test plan
- Reset: assert reset mid-count with DATA=16'h1234 → out_port=16'h0000, out_blank=4'b0000, STATUS=2'b01 immediately, without waiting for a clk edge.
- Atomic ops:
  - write DATA=16'h00F0, SET 16'h000F → DATA=16'h00FF;
  - CLEAR 16'h00F0 → DATA=16'h000F;
  - TOGGLE 16'hFFFF → DATA=16'hFFF0;
  - readback at address 4 returns 32'h0000FFF0.
- Blink: BLINK_EN=4'b0101, BLINK_PERIOD=3 → out_blank alternates 4'b0000 / 4'b0101 every 4 cycles; phase toggles first 4 cycles after the period write; out_port stays constant.
- Period edge: BLINK_PERIOD=0 while phase=0 → no period write: phase stays 0 until write; after write to 0: phase=1, out_blank=0, held indefinitely.
- Collision: write BLINK_PERIOD=7 in the cycle cnt expires → cnt=7, phase=1, no extra toggle.
- Width: writedata=32'hABCD_1234 to DATA → out_port=16'h1234, readback 32'h0000_1234; address 7 reads 0.
